// File: rtl/tick_shift_register_pkg.sv
// Shared definitions for the tick-gated shift register: the operation encoding
// (ordered by priority) and a constant-evaluable ceil(log2) helper.
`timescale 1ns/1ps
package tick_shift_register_pkg;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_SHIFT = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Higher-priority controls mask the lower ones completely.
  function automatic op_e decode_op(input logic clear, input logic load, input logic shift);
    if (clear)      return OP_CLEAR;
    else if (load)  return OP_LOAD;
    else if (shift) return OP_SHIFT;
    else            return OP_HOLD;
  endfunction

endpackage

// File: rtl/tick_register_stage.sv
// One stage of the chain: data and valid registers with asynchronous active-high
// reset, updated on the clock edge selected by INVERT_CLOCK when en_i is high.
`timescale 1ns/1ps
module tick_register_stage #(
  parameter int unsigned NR_OF_BITS   = 8,
  parameter int unsigned INVERT_CLOCK = 0
) (
  input  logic                  s_clock,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic [NR_OF_BITS-1:0] data_d_i,
  input  logic                  valid_d_i,
  output logic [NR_OF_BITS-1:0] data_q_o,
  output logic                  valid_q_o
);

  logic                  active_clock;
  logic [NR_OF_BITS-1:0] data_q;
  logic                  valid_q;

  // Inverting the clock lets every stage use a rising-edge flop.
  assign active_clock = (INVERT_CLOCK != 0) ? ~s_clock : s_clock;

  always_ff @(posedge active_clock or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (en_i) begin
      data_q  <= data_d_i;
      valid_q <= valid_d_i;
    end
  end

  assign data_q_o  = data_q;
  assign valid_q_o = valid_q;

endmodule

// File: rtl/tick_shift_register.sv
// Tick-gated multi-stage register chain with serial shift, parallel load,
// synchronous clear and per-stage valid tracking; stage 0 is the input end.
`timescale 1ns/1ps
module tick_shift_register
  import tick_shift_register_pkg::*;
#(
  parameter int unsigned NR_OF_BITS   = 8,
  parameter int unsigned NR_OF_STAGES = 4,
  parameter int unsigned INVERT_CLOCK = 0
) (
  input  logic                                 s_clock,
  input  logic                                 reset,
  input  logic                                 clock_enable,
  input  logic                                 tick,
  input  logic                                 clear,
  input  logic                                 load,
  input  logic                                 shift,
  input  logic [NR_OF_BITS-1:0]                d,
  input  logic                                 d_valid,
  input  logic [NR_OF_BITS*NR_OF_STAGES-1:0]   parallel_d,
  output logic [NR_OF_BITS-1:0]                q,
  output logic                                 q_valid,
  output logic [NR_OF_BITS*NR_OF_STAGES-1:0]   parallel_q,
  output logic [$clog2(NR_OF_STAGES+1)-1:0]    fill_count
);

  localparam int CNT_W = $clog2(NR_OF_STAGES + 1);

  logic                    advance;
  logic                    update_en;
  op_e                     op;
  logic [NR_OF_BITS-1:0]   stage_q [NR_OF_STAGES];
  logic [NR_OF_BITS-1:0]   stage_d [NR_OF_STAGES];
  logic [NR_OF_STAGES-1:0] valid_q;
  logic [NR_OF_STAGES-1:0] valid_d;
  logic [CNT_W-1:0]        fill_d;

  assign advance   = clock_enable & tick;
  assign op        = decode_op(clear, load, shift);
  assign update_en = advance && (op != OP_HOLD);

  always_comb begin
    for (int i = 0; i < NR_OF_STAGES; i++) begin
      stage_d[i] = stage_q[i];
      valid_d[i] = valid_q[i];
    end
    case (op)
      OP_CLEAR: begin
        for (int i = 0; i < NR_OF_STAGES; i++) begin
          stage_d[i] = '0;
          valid_d[i] = 1'b0;
        end
      end
      OP_LOAD: begin
        for (int i = 0; i < NR_OF_STAGES; i++) begin
          stage_d[i] = parallel_d[i*NR_OF_BITS +: NR_OF_BITS];
          valid_d[i] = 1'b1;
        end
      end
      OP_SHIFT: begin
        // The last stage's old contents fall off the end; nothing wraps around.
        stage_d[0] = d;
        valid_d[0] = d_valid;
        for (int i = 1; i < NR_OF_STAGES; i++) begin
          stage_d[i] = stage_q[i-1];
          valid_d[i] = valid_q[i-1];
        end
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < NR_OF_STAGES; g++) begin : g_stage
    tick_register_stage #(
      .NR_OF_BITS   (NR_OF_BITS),
      .INVERT_CLOCK (INVERT_CLOCK)
    ) u_stage (
      .s_clock   (s_clock),
      .reset     (reset),
      .en_i      (update_en),
      .data_d_i  (stage_d[g]),
      .valid_d_i (valid_d[g]),
      .data_q_o  (stage_q[g]),
      .valid_q_o (valid_q[g])
    );
    assign parallel_q[g*NR_OF_BITS +: NR_OF_BITS] = stage_q[g];
  end

  always_comb begin
    fill_d = '0;
    for (int i = 0; i < NR_OF_STAGES; i++) begin
      fill_d = fill_d + CNT_W'(valid_q[i]);
    end
  end

  assign q          = stage_q[NR_OF_STAGES-1];
  assign q_valid    = valid_q[NR_OF_STAGES-1];
  assign fill_count = fill_d;

endmodule

// File: tb/tb_tick_shift_register.sv
// Bench for tick_shift_register: directed scenarios plus randomized control traffic
// compared against a queue-based model of the chain contents.
`timescale 1ns/1ps
module tb_tick_shift_register;

  localparam int NB = 8;
  localparam int NS = 4;
  localparam int PW = NB * NS;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // DUT A: 4 stages, rising edge
  logic          a_ce = 0, a_tick = 0, a_clear = 0, a_load = 0, a_shift = 0, a_dv = 0;
  logic [NB-1:0] a_d = '0;
  logic [PW-1:0] a_pd = '0;
  logic [NB-1:0] a_q;
  logic          a_qv;
  logic [PW-1:0] a_pq;
  logic [2:0]    a_fill;

  tick_shift_register #(.NR_OF_BITS(NB), .NR_OF_STAGES(NS), .INVERT_CLOCK(0)) u_dut_a (
    .s_clock(clk), .reset(reset), .clock_enable(a_ce), .tick(a_tick), .clear(a_clear),
    .load(a_load), .shift(a_shift), .d(a_d), .d_valid(a_dv), .parallel_d(a_pd),
    .q(a_q), .q_valid(a_qv), .parallel_q(a_pq), .fill_count(a_fill)
  );

  // DUT B: 1 stage, falling edge
  logic          b_ce = 0, b_tick = 0, b_clear = 0, b_load = 0, b_shift = 0, b_dv = 0;
  logic [NB-1:0] b_d = '0;
  logic [NB-1:0] b_pd = '0;
  logic [NB-1:0] b_q;
  logic          b_qv;
  logic [NB-1:0] b_pq;
  logic [0:0]    b_fill;

  tick_shift_register #(.NR_OF_BITS(NB), .NR_OF_STAGES(1), .INVERT_CLOCK(1)) u_dut_b (
    .s_clock(clk), .reset(reset), .clock_enable(b_ce), .tick(b_tick), .clear(b_clear),
    .load(b_load), .shift(b_shift), .d(b_d), .d_valid(b_dv), .parallel_d(b_pd),
    .q(b_q), .q_valid(b_qv), .parallel_q(b_pq), .fill_count(b_fill)
  );

  // Scoreboard: exp_q[0] is the input end of the chain, exp_q[NS-1] drives q
  logic [NB-1:0] exp_q[$];
  logic          expv_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    expv_q.delete();
    for (int i = 0; i < NS; i++) begin
      exp_q.push_back('0);
      expv_q.push_back(1'b0);
    end
  endtask

  task automatic model_apply(input logic ce, input logic tk, input logic cl, input logic ld,
                             input logic sh, input logic [NB-1:0] dd, input logic dv,
                             input logic [PW-1:0] pd);
    if (!(ce && tk)) return;
    if (cl) begin
      model_reset();
    end else if (ld) begin
      for (int i = 0; i < NS; i++) begin
        exp_q[i]  = pd[i*NB +: NB];
        expv_q[i] = 1'b1;
      end
    end else if (sh) begin
      exp_q.push_front(dd);
      expv_q.push_front(dv);
      void'(exp_q.pop_back());
      void'(expv_q.pop_back());
    end
  endtask

  task automatic check_a(input string tag);
    logic [PW-1:0] par;
    int fill;
    par  = '0;
    fill = 0;
    for (int i = 0; i < NS; i++) begin
      par[i*NB +: NB] = exp_q[i];
      fill += int'(expv_q[i]);
    end
    check_val({tag, ".parallel_q"}, 64'(a_pq), 64'(par));
    check_val({tag, ".q"}, 64'(a_q), 64'(exp_q[NS-1]));
    check_val({tag, ".q_valid"}, 64'(a_qv), 64'(expv_q[NS-1]));
    check_val({tag, ".fill_count"}, 64'(a_fill), 64'(fill));
  endtask

  // Driver: apply inputs away from the edge, advance one rising edge, then compare.
  task automatic cycle(input logic ce, input logic tk, input logic cl, input logic ld,
                       input logic sh, input logic [NB-1:0] dd, input logic dv,
                       input logic [PW-1:0] pd, input string tag);
    a_ce = ce; a_tick = tk; a_clear = cl; a_load = ld; a_shift = sh;
    a_d = dd; a_dv = dv; a_pd = pd;
    @(posedge clk);
    if (reset) model_reset();
    else       model_apply(ce, tk, cl, ld, sh, dd, dv, pd);
    #1;
    check_a(tag);
  endtask

  logic [NB-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    model_reset();

    // Power-up / reset held
    #12;
    check_a("reset_hold");
    check_val("b_reset.q", 64'(b_q), 64'h0);
    check_val("b_reset.fill", 64'(b_fill), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Serial shift, tick every edge
    for (int k = 0; k < 4; k++) begin
      cycle(1, 1, 0, 0, 1, vals[k], 1, '0, "shift4");
      check_val("shift4.fill_step", 64'(a_fill), 64'(k + 1));
    end
    check_val("shift4.q_const", 64'(a_q), 64'h11);
    check_val("shift4.qv_const", 64'(a_qv), 64'h1);

    // Tick every other edge
    cycle(1, 1, 1, 0, 0, '0, 0, '0, "clear");
    for (int e = 0; e < 8; e++) begin
      cycle(1, logic'(e % 2 == 0), 0, 0, 1, vals[e/2], 1, '0, "tick_alt");
    end
    check_val("tick_alt.q_const", 64'(a_q), 64'h11);
    check_val("tick_alt.fill_const", 64'(a_fill), 64'h4);

    // clock_enable low blocks everything
    cycle(0, 1, 1, 1, 1, 8'hFF, 1, '1, "ce_off");
    check_val("ce_off.q_const", 64'(a_q), 64'h11);

    // Parallel load then shift with invalid data
    cycle(1, 1, 0, 1, 0, '0, 0, 32'hDDCCBBAA, "load");
    check_val("load.par_const", 64'(a_pq), 64'hDDCCBBAA);
    check_val("load.q_const", 64'(a_q), 64'hDD);
    check_val("load.fill_const", 64'(a_fill), 64'h4);
    cycle(1, 1, 0, 0, 1, 8'hEE, 0, '0, "shift_ee");
    check_val("shift_ee.par_const", 64'(a_pq), 64'hCCBBAAEE);
    check_val("shift_ee.fill_const", 64'(a_fill), 64'h3);

    // Simultaneous controls
    cycle(1, 1, 1, 1, 1, 8'h77, 1, 32'h12345678, "clr_ld_sh");
    check_val("clr_ld_sh.par_const", 64'(a_pq), 64'h0);
    check_val("clr_ld_sh.fill_const", 64'(a_fill), 64'h0);
    cycle(1, 1, 0, 1, 1, 8'h99, 1, 32'h12345678, "ld_sh");
    check_val("ld_sh.par_const", 64'(a_pq), 64'h12345678);
    cycle(1, 0, 1, 1, 1, 8'h55, 1, 32'hFFFFFFFF, "tick0");
    check_val("tick0.par_const", 64'(a_pq), 64'h12345678);

    // Asynchronous reset pulse between edges
    #2;
    reset = 1'b1;
    #1;
    check_val("async_rst.q", 64'(a_q), 64'h0);
    check_val("async_rst.par", 64'(a_pq), 64'h0);
    check_val("async_rst.fill", 64'(a_fill), 64'h0);
    check_val("async_rst.qv", 64'(a_qv), 64'h0);
    reset = 1'b0;
    model_reset();
    #1;

    // Reset held across an advancing edge wins over the update
    cycle(1, 1, 0, 1, 0, '0, 0, 32'hAABBCCDD, "pre_rst_load");
    reset = 1'b1;
    cycle(1, 1, 0, 0, 1, 8'h33, 1, '0, "rst_edge");
    check_val("rst_edge.par_const", 64'(a_pq), 64'h0);
    reset = 1'b0;
    cycle(1, 1, 0, 0, 1, 8'h42, 1, '0, "post_rst");
    check_val("post_rst.stage0", 64'(a_pq[NB-1:0]), 64'h42);
    check_val("post_rst.fill", 64'(a_fill), 64'h1);

    // Randomized traffic
    repeat (300) begin
      cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 7) == 0),
            logic'($urandom_range(0, 1)), NB'($urandom), logic'($urandom_range(0, 1)),
            PW'($urandom), "rand");
    end

    // Single stage on the falling edge
    @(negedge clk);
    #1;
    b_ce = 1; b_tick = 1; b_shift = 1; b_d = 8'h5A; b_dv = 1;
    @(posedge clk);
    #1;
    check_val("b_rise.q", 64'(b_q), 64'h0);
    check_val("b_rise.fill", 64'(b_fill), 64'h0);
    @(negedge clk);
    #1;
    check_val("b_fall.q", 64'(b_q), 64'h5A);
    check_val("b_fall.qv", 64'(b_qv), 64'h1);
    check_val("b_fall.fill", 64'(b_fill), 64'h1);
    check_val("b_fall.par", 64'(b_pq), 64'h5A);
    b_d = 8'hC3; b_dv = 0;
    @(negedge clk);
    #1;
    check_val("b_shift2.q", 64'(b_q), 64'hC3);
    check_val("b_shift2.fill", 64'(b_fill), 64'h0);
    b_shift = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
